audio_pll_lock_sequencer: RTL
=============================

// Module: audio_pll_lock_sequencer
// PURPOSE
//  Sequences the audio PLL (50 MHz ref -> 18.432 MHz audio clock) from the system clock domain.
//  Drives the PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock stability.
//  Releases the audio-domain reset only on a stable lock; a lock loss forces re-sequencing.
//  Sits between the PLL wrapper and the audio CODEC/FIFO reset tree; status feeds a CSR.
// PARAMETERS
//  RST_HOLD_CYCLES  16     clk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT     65536  clk cycles allowed in WAIT_LOCK+STABILIZE per attempt (>=2)
//  LOCK_STABLE      1024   consecutive synced-locked cycles required before release (>=1)
//  MAX_RETRIES      3      retries after the first attempt before FAILED (>=0)
// PORTS
//  clk              in   1  system clock, 50 MHz
//  reset_n          in   1  synchronous active-low reset
//  restart          in   1  single-cycle pulse: restart sequence from any state
//  pll_locked       in   1  PLL locked, asynchronous to clk
//  pll_rst          out  1  PLL reset, active high, registered
//  audio_reset_n    out  1  audio-domain reset, active low, registered
//  status_locked    out  1  1 iff state==RUNNING
//  status_failed    out  1  1 iff state==FAILED
//  retry_count      out  RW retries used this sequence; RW=$clog2(MAX_RETRIES+1), min 1
//  lock_loss_count  out  8  RUNNING->lock-loss events since reset_n, saturates at 255
// BEHAVIOUR
//  - One clock, clk; reset_n synchronous, active low. All outputs registered.
//  - Reset values: state=RESET_PLL, pll_rst=1, audio_reset_n=0, status_*=0, counters=0.
//  - pll_locked passes a 2-flop synchronizer -> lk (2-cycle latency); FSM uses lk only.
//  - RESET_PLL: pll_rst=1; hold counter runs; after RST_HOLD_CYCLES cycles -> WAIT_LOCK, pll_rst=0,
//    attempt timer cleared.
//  - WAIT_LOCK: timer++; lk=1 -> STABILIZE (stable cnt=1).
//  - STABILIZE: timer++; lk=1 -> stable cnt++; cnt==LOCK_STABLE -> RUNNING; lk=0 -> WAIT_LOCK, cnt=0,
//    timer NOT cleared (flapping still times out).
//  - Timeout: timer==LOCK_TIMEOUT-1 in WAIT_LOCK/STABILIZE: retry_count==MAX_RETRIES -> FAILED,
//    else retry_count++ and -> RESET_PLL.
//  - RUNNING: audio_reset_n=1, status_locked=1; lk=0 -> RESET_PLL, audio_reset_n=0 on same edge,
//    lock_loss_count++ (sat), retry_count=0.
//  - FAILED: pll_rst=1 (PLL held off), audio_reset_n=0, status_failed=1; exits only via restart.
//  - restart (any state): -> RESET_PLL next edge, hold counter/timer/retry_count cleared,
//    lock_loss_count kept. Beats timeout and lock loss same cycle (no count increment).
//  - reset_n has priority over everything incl. restart; mid-sequence reset restarts cleanly.
//  - Outputs follow state registered: audio_reset_n high exactly in RUNNING cycles.
// STRUCTURE
//  - Package audio_pll_seq_pkg: state enum {RESET_PLL, WAIT_LOCK, STABILIZE, RUNNING, FAILED},
//    width helper function for counter sizing.
//  - Sub-module audio_pll_lock_sync: 2-flop bit synchronizer, reset to 0; one instance.
//  - Counter widths from $clog2 of parameters; no counter wraps (all compare-and-clear).
// TESTING (params RST_HOLD=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=2)
//  1 reset_n released, pll_locked rises 10 cycles later, held -> pll_rst low 4 cycles after release;
//    audio_reset_n rises 11 cycles after pll_locked (2 sync + 8 stable + 1); status_locked=1.
//  2 pll_locked held 0 -> 3 pll_rst pulses of 4 cycles; status_failed=1 after 3*(4+32) cycles;
//    retry_count=2; audio_reset_n stays 0; pll_rst stays 1.
//  3 Lock glitch low for 1 cycle after 5 stable cycles -> no release; release needs 8 fresh
//    consecutive cycles; persistent flapping every 6 cycles -> timeout retry at 32.
//  4 In RUNNING drop pll_locked -> audio_reset_n=0 and pll_rst=1 3 cycles later; lock_loss_count=1,
//    retry_count=0; relock -> RUNNING again.
//  5 restart pulse in FAILED -> RESET_PLL next edge, status_failed=0, retry_count=0; restart same
//    cycle as lock loss in RUNNING -> lock_loss_count unchanged.
//  6 reset_n low mid-STABILIZE -> next edge all outputs at reset values, lock_loss_count=0.

Source files
------------

// File: rtl/audio_pll_seq_pkg.sv
// Shared types and sizing helpers for the audio PLL lock sequencer.
package audio_pll_seq_pkg;

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StStabilize,
      StRunning,
      StFailed
   } state_e;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/audio_pll_lock_sync.sv
// Two-flop bit synchronizer for the asynchronous PLL lock indication.
module audio_pll_lock_sync (
   input  logic clk_i,
   input  logic reset_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/audio_pll_lock_sequencer.sv
// Audio PLL bring-up: PLL reset hold, lock wait with timeout and retries, lock qualification,
// audio reset release and lock-loss recovery.
module audio_pll_lock_sequencer
   import audio_pll_seq_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT    = 65536,
   parameter int unsigned LOCK_STABLE     = 1024,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,
   input  logic                                  restart_i,
   input  logic                                  pll_locked_i,
   output logic                                  pll_rst_o,
   output logic                                  audio_reset_n_o,
   output logic                                  status_locked_o,
   output logic                                  status_failed_o,
   output logic [cnt_width(MAX_RETRIES + 1)-1:0] retry_count_o,
   output logic [7:0]                            lock_loss_count_o
);

   localparam int unsigned HoldW   = cnt_width(RST_HOLD_CYCLES);
   localparam int unsigned TimerW  = cnt_width(LOCK_TIMEOUT);
   localparam int unsigned StableW = cnt_width(LOCK_STABLE + 1);
   localparam int unsigned RetryW  = cnt_width(MAX_RETRIES + 1);

   localparam logic [HoldW-1:0]   HoldLast   = HoldW'(RST_HOLD_CYCLES - 1);
   localparam logic [TimerW-1:0]  TimerLast  = TimerW'(LOCK_TIMEOUT - 1);
   localparam logic [StableW-1:0] StableDone = StableW'(LOCK_STABLE);
   localparam logic [RetryW-1:0]  RetryMax   = RetryW'(MAX_RETRIES);

   state_e              state_q, state_d;
   logic [HoldW-1:0]    hold_q, hold_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [StableW-1:0]  stable_q, stable_d;
   logic [RetryW-1:0]   retry_q, retry_d;
   logic [7:0]          loss_q, loss_d;
   logic                pll_rst_q, audio_reset_n_q, locked_q, failed_q;
   logic                lk;

   audio_pll_lock_sync u_lock_sync (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .d_i       (pll_locked_i),
      .q_o       (lk)
   );

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      timer_d  = timer_q;
      stable_d = stable_q;
      retry_d  = retry_q;
      loss_d   = loss_q;
      if (restart_i) begin
         state_d  = StResetPll;
         hold_d   = '0;
         timer_d  = '0;
         stable_d = '0;
         retry_d  = '0;
      end else begin
         unique case (state_q)
            StResetPll: begin
               if (hold_q == HoldLast) begin
                  state_d  = StWaitLock;
                  hold_d   = '0;
                  timer_d  = '0;
                  stable_d = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            StWaitLock, StStabilize: begin
               // The attempt timer spans both states so a flapping lock still times out.
               if (timer_q == TimerLast) begin
                  timer_d  = '0;
                  stable_d = '0;
                  hold_d   = '0;
                  if (retry_q == RetryMax) begin
                     state_d = StFailed;
                  end else begin
                     retry_d = retry_q + 1'b1;
                     state_d = StResetPll;
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
                  if (!lk) begin
                     state_d  = StWaitLock;
                     stable_d = '0;
                  end else if (state_q == StWaitLock) begin
                     state_d  = StStabilize;
                     stable_d = StableW'(1);
                  end else if (stable_q == StableDone) begin
                     state_d = StRunning;
                  end else begin
                     stable_d = stable_q + 1'b1;
                  end
               end
            end
            StRunning: begin
               if (!lk) begin
                  state_d  = StResetPll;
                  hold_d   = '0;
                  stable_d = '0;
                  retry_d  = '0;
                  if (loss_q != 8'hFF) begin
                     loss_d = loss_q + 1'b1;
                  end
               end
            end
            StFailed: state_d = StFailed;
            default:  state_d = StResetPll;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q         <= StResetPll;
         hold_q          <= '0;
         timer_q         <= '0;
         stable_q        <= '0;
         retry_q         <= '0;
         loss_q          <= '0;
         pll_rst_q       <= 1'b1;
         audio_reset_n_q <= 1'b0;
         locked_q        <= 1'b0;
         failed_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         hold_q          <= hold_d;
         timer_q         <= timer_d;
         stable_q        <= stable_d;
         retry_q         <= retry_d;
         loss_q          <= loss_d;
         pll_rst_q       <= (state_d == StResetPll) || (state_d == StFailed);
         audio_reset_n_q <= (state_d == StRunning);
         locked_q        <= (state_d == StRunning);
         failed_q        <= (state_d == StFailed);
      end
   end

   assign pll_rst_o         = pll_rst_q;
   assign audio_reset_n_o   = audio_reset_n_q;
   assign status_locked_o   = locked_q;
   assign status_failed_o   = failed_q;
   assign retry_count_o     = retry_q;
   assign lock_loss_count_o = loss_q;

endmodule
